mod_exp_engine: RTL and testbench

Parametrised iterative modular exponentiation core that computes result = Base^exponent mod N for the RSA datapath. It replaces the fixed 6-bit lookup-table/counter exponentiator with a native shift-subtract (Blakley) modular multiplier, so no memory is needed. It uses left-to-right square-and-multiply, valid/ready handshakes on input and output, an optional constant-time mode, and error reporting for N = 0.

---
 rtl/mod_exp_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_mod_exp_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_engine.sv
// rtl/mod_exp_engine.sv - iterative modular exponentiation core (Base^exponent mod N)
//
// Left-to-right square-and-multiply built on a bit-serial Blakley modular
// multiplier (one shift/subtract step per clock). No memory is used.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      asynchronous active-high reset
//   in_valid   operands valid
//   in_ready   high only in IDLE; accept = in_valid & in_ready
//   Base       base (any value, may be >= N)
//   exponent   exponent
//   N          modulus
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   result     Base^exponent mod N, 0 whenever out_valid = 0
//   err        qualified by out_valid; 1 = N was 0
//   busy       high in every state except IDLE
module mod_exp_engine #(
  parameter int WIDTH      = 6,
  parameter int EXP_WIDTH  = 6,
  parameter int CONST_TIME = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     Base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     N,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 err,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(EXP_WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SQR,
    S_MUL,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [WIDTH-1:0]     b_q, b_d;      // reduced base, always < N
  logic [WIDTH-1:0]     r_q, r_d;      // running result
  logic [WIDTH-1:0]     p_q, p_d;      // Blakley partial product, always < N
  logic [CW-1:0]        cnt_q, cnt_d;  // bit position inside a WIDTH-cycle phase
  logic [IW-1:0]        idx_q, idx_d;  // current exponent bit
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  // Shared datapath, WIDTH+1 bits wide so 2x and x+y of values < N never overflow.
  logic [WIDTH:0]   n_ext;
  logic [WIDTH-1:0] addend;
  logic             mult_bit;
  logic [WIDTH:0]   p_dbl, p_red1, p_add, p_next;
  logic [WIDTH-1:0] p_new;
  logic [WIDTH:0]   b_dbl, b_next;
  logic [WIDTH-1:0] b_new;
  logic             last_step, idx_zero, exp_bit;

  assign n_ext     = {1'b0, n_q};
  // SQR computes R*R, MUL computes R*B; the multiplier bits always come from R.
  assign addend    = (state_q == S_MUL) ? b_q : r_q;
  assign mult_bit  = r_q[cnt_q];
  assign p_dbl     = {p_q, 1'b0};
  assign p_red1    = (p_dbl >= n_ext) ? (p_dbl - n_ext) : p_dbl;
  assign p_add     = mult_bit ? (p_red1 + {1'b0, addend}) : p_red1;
  assign p_next    = (p_add >= n_ext) ? (p_add - n_ext) : p_add;
  assign p_new     = WIDTH'(p_next);

  // Base reduction: shift in one base bit; 2B+1 < 2N so one subtract suffices.
  assign b_dbl     = {b_q, base_q[cnt_q]};
  assign b_next    = (b_dbl >= n_ext) ? (b_dbl - n_ext) : b_dbl;
  assign b_new     = WIDTH'(b_next);

  assign last_step = (cnt_q == '0);
  assign idx_zero  = (idx_q == '0);
  assign exp_bit   = exp_q[idx_q];

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    exp_d       = exp_q;
    n_d         = n_q;
    b_d         = b_q;
    r_d         = r_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          base_d = Base;
          exp_d  = exponent;
          n_d    = N;
          if (N == '0) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            result_d    = '0;
            err_d       = 1'b1;
          end else begin
            state_d = S_PRE;
            r_d     = (N == WIDTH'(1)) ? '0 : WIDTH'(1);
            b_d     = '0;
            p_d     = '0;
            cnt_d   = CNT_LAST;
            idx_d   = IDX_LAST;
            err_d   = 1'b0;
          end
        end
      end

      S_PRE: begin
        b_d = b_new;
        if (last_step) begin
          state_d = S_SQR;
          cnt_d   = CNT_LAST;
          p_d     = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_SQR: begin
        p_d = p_new;
        if (last_step) begin
          r_d   = p_new;
          p_d   = '0;
          cnt_d = CNT_LAST;
          if (exp_bit || (CONST_TIME != 0)) begin
            state_d = S_MUL;
          end else if (idx_zero) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            result_d    = p_new;
          end else begin
            idx_d = idx_q - IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_MUL: begin
        p_d = p_new;
        if (last_step) begin
          // In constant-time mode a zero exponent bit still runs the multiply
          // but the product is dropped here.
          if (exp_bit) begin
            r_d = p_new;
          end
          p_d   = '0;
          cnt_d = CNT_LAST;
          if (idx_zero) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            result_d    = exp_bit ? p_new : r_q;
          end else begin
            state_d = S_SQR;
            idx_d   = idx_q - IDX_ONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          result_d    = '0;
          err_d       = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        result_d    = '0;
        err_d       = 1'b0;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      exp_q       <= '0;
      n_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      exp_q       <= exp_d;
      n_q         <= n_d;
      b_q         <= b_d;
      r_q         <= r_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// tb/tb_mod_exp_engine.sv - scoreboard bench for mod_exp_engine (variable and constant time)
module tb_mod_exp_engine;

  localparam int W = 6;
  localparam int E = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   in_valid, in_ready, out_valid, out_ready, err_s, busy_s;
  logic [W-1:0] base_s [2];
  logic [W-1:0] n_s    [2];
  logic [W-1:0] res_s  [2];
  logic [E-1:0] exp_s  [2];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         err;
    logic [15:0]  lat;
  } exp_t;

  exp_t         sbq [2][$];
  int           cyc      [2];
  bit           tracking [2];
  bit           seen     [2];
  bit           hs_prev  [2];
  logic [W-1:0] held_res [2];
  logic         held_err [2];
  exp_t         mon_e;

  mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(E), .CONST_TIME(0)) u_dut0 (
    .clk(clk), .reset(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .Base(base_s[0]), .exponent(exp_s[0]), .N(n_s[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(res_s[0]), .err(err_s[0]), .busy(busy_s[0])
  );

  mod_exp_engine #(.WIDTH(W), .EXP_WIDTH(E), .CONST_TIME(1)) u_dut1 (
    .clk(clk), .reset(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .Base(base_s[1]), .exponent(exp_s[1]), .N(n_s[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(res_s[1]), .err(err_s[1]), .busy(busy_s[1])
  );

  // Reference: plain modular power by repeated multiplication, latency from the closed form.
  function automatic exp_t ref_model(input int base, input int e, input int n, input int ct);
    exp_t m;
    int r, b, k;
    if (n == 0) begin
      m.res = '0;
      m.err = 1'b1;
      m.lat = 16'd1;
      return m;
    end
    r = 1 % n;
    b = base % n;
    for (int i = 0; i < e; i++) r = (r * b) % n;
    k = 0;
    for (int i = 0; i < E; i++) k += (e >> i) & 1;
    m.res = W'(r);
    m.err = 1'b0;
    m.lat = 16'(1 + W * (1 + E + ((ct != 0) ? E : k)));
    return m;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", name, d, act, req, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each new result.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        sbq[d].delete();
        tracking[d] = 1'b0;
        seen[d]     = 1'b0;
        hs_prev[d]  = 1'b0;
      end else begin
        if (tracking[d]) cyc[d]++;
        if (hs_prev[d]) begin
          check("after_hs_out_valid", d, 32'(out_valid[d]), 0);
          check("after_hs_in_ready", d, 32'(in_ready[d]), 1);
          check("after_hs_result", d, 32'(res_s[d]), 0);
          seen[d] = 1'b0;
        end else if (out_valid[d] && !seen[d]) begin
          if (sbq[d].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result dut%0d actual=%0d required=no result", d, res_s[d]);
          end else begin
            mon_e = sbq[d].pop_front();
            check("result", d, 32'(res_s[d]), 32'(mon_e.res));
            check("err", d, 32'(err_s[d]), 32'(mon_e.err));
            check("latency", d, tracking[d] ? cyc[d] : -1, 32'(mon_e.lat));
          end
          seen[d]     = 1'b1;
          tracking[d] = 1'b0;
          held_res[d] = res_s[d];
          held_err[d] = err_s[d];
        end else if (seen[d]) begin
          if (!out_valid[d]) begin
            check("out_valid_held", d, 0, 1);
            seen[d] = 1'b0;
          end else begin
            check("held_result", d, 32'(res_s[d]), 32'(held_res[d]));
            check("held_err", d, 32'(err_s[d]), 32'(held_err[d]));
            check("done_in_ready", d, 32'(in_ready[d]), 0);
          end
        end else begin
          check("idle_result_zero", d, 32'(res_s[d]), 0);
        end
        hs_prev[d] = out_valid[d] & out_ready[d];
        if (in_valid[d] && in_ready[d]) begin
          tracking[d] = 1'b1;
          cyc[d]      = 0;
        end
      end
    end
  end

  // All driver actions happen 1 time unit after a rising edge.
  task automatic send(input int d, input int base, input int e, input int n);
    int g = 0;
    while (!in_ready[d] && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready[d]) begin
      check("send_ready_timeout", d, 0, 1);
      return;
    end
    base_s[d]   = W'(base);
    exp_s[d]    = E'(e);
    n_s[d]      = W'(n);
    in_valid[d] = 1'b1;
    sbq[d].push_back(ref_model(base, e, n, d));
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    // Operands are latched; changing them now must not matter.
    base_s[d]   = W'($urandom);
    exp_s[d]    = E'($urandom);
    n_s[d]      = W'($urandom);
  endtask

  task automatic wait_done(input int d);
    int g = 0;
    while (!(out_valid[d] && out_ready[d]) && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (!(out_valid[d] && out_ready[d])) begin
      check("done_timeout", d, 0, 1);
      return;
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int d, input int base, input int e, input int n);
    send(d, base, e, n);
    wait_done(d);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, e0, b1, e1, g;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      base_s[d] = '0;
      exp_s[d]  = '0;
      n_s[d]    = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", d, 32'(in_ready[d]), 1);
      check("rst_out_valid", d, 32'(out_valid[d]), 0);
      check("rst_result", d, 32'(res_s[d]), 0);
      check("rst_err", d, 32'(err_s[d]), 0);
      check("rst_busy", d, 32'(busy_s[d]), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases on both engines
    fork
      run(0, 4, 13, 33);
      run(1, 4, 13, 33);
    join
    fork
      run(0, 50, 2, 7);
      run(1, 0, 0, 33);
    join
    fork
      run(0, 0, 0, 33);
      run(1, 50, 2, 7);
    join
    fork
      run(0, 5, 3, 1);
      run(1, 5, 3, 1);
    join
    fork
      run(0, 9, 4, 0);
      run(1, 9, 4, 0);
    join

    // Backpressure with an ignored in_valid during DONE
    out_ready[0] = 1'b0;
    send(0, 4, 13, 33);
    g = 0;
    while (!out_valid[0] && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    check("bp_reached_done", 0, 32'(out_valid[0]), 1);
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = 1'b1;
      base_s[0]   = W'($urandom);
      exp_s[0]    = E'($urandom);
      n_s[0]      = W'($urandom_range(1, 63));
      @(posedge clk); #1;
      check("bp_in_ready", 0, 32'(in_ready[0]), 0);
      check("bp_out_valid", 0, 32'(out_valid[0]), 1);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 0, 32'(out_valid[0]), 0);
    check("bp_release_busy", 0, 32'(busy_s[0]), 0);
    @(posedge clk); #1;

    // Reset in the middle of an operation
    send(0, 4, 13, 33);
    repeat (19) @(posedge clk);
    #1;
    check("mid_op_busy", 0, 32'(busy_s[0]), 1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 0, 32'(out_valid[0]), 0);
    check("abort_result", 0, 32'(res_s[0]), 0);
    check("abort_busy", 0, 32'(busy_s[0]), 0);
    check("abort_in_ready", 0, 32'(in_ready[0]), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(0, 3, 5, 13);

    // Random sweep over every nonzero modulus
    for (int n = 1; n < 64; n++) begin
      b0 = $urandom_range(0, 63);
      e0 = $urandom_range(0, 63);
      b1 = $urandom_range(0, 63);
      e1 = $urandom_range(0, 63);
      fork
        run(0, b0, e0, n);
        run(1, b1, e1, n);
      join
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 0, 32'(sbq[0].size()), 0);
    check("scoreboard_empty", 1, 32'(sbq[1].size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
